// File: rtl/err_pkg.sv
// Shared types and width helpers for the timing-error recovery controller.
package err_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECOVER = 2'd1,
        REPLAY  = 2'd2
    } state_e;

    localparam int unsigned DEF_WINDOW       = 16;
    localparam int unsigned DEF_STALL_CYCLES = 1;
    localparam int unsigned DEF_WCNT_W       = $clog2(DEF_WINDOW);
    localparam int unsigned DEF_SCNT_W       = $clog2(DEF_STALL_CYCLES + 1);

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/err_rate_monitor.sv
// Windowed error-rate monitor: counts accepted errors per WINDOW cycles and
// requests clock throttling once THRESH errors land in one window.
module err_rate_monitor
    import err_pkg::*;
#(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned THRESH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_accept,
    output logic o_throttle
);

    localparam int unsigned WCNT_W = cnt_width(WINDOW);
    localparam int unsigned WERR_W = cnt_width(THRESH + 1);

    logic [WCNT_W-1:0] r_wcnt;
    logic [WERR_W-1:0] r_werr;
    logic              r_throttle;
    logic              w_wrap;
    logic              w_werr_full;
    logic [WERR_W-1:0] w_werr_inc;

    assign w_wrap      = (r_wcnt == WCNT_W'(WINDOW - 1));
    assign w_werr_full = (r_werr == WERR_W'(THRESH));
    assign w_werr_inc  = w_werr_full ? r_werr : r_werr + WERR_W'(1);

    // An error accepted on the wrap cycle belongs to the window just starting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt     <= '0;
            r_werr     <= '0;
            r_throttle <= 1'b0;
        end else if (w_wrap) begin
            r_wcnt     <= '0;
            r_werr     <= i_accept ? WERR_W'(1) : '0;
            r_throttle <= w_werr_full || (i_accept && (THRESH == 1));
        end else begin
            r_wcnt <= r_wcnt + WCNT_W'(1);
            if (i_accept) begin
                r_werr <= w_werr_inc;
                if (w_werr_inc == WERR_W'(THRESH)) begin
                    r_throttle <= 1'b1;
                end
            end
        end
    end

    assign o_throttle = r_throttle;

endmodule

// File: rtl/error_recovery_ctrl.sv
// Timing-error recovery: stalls, restores the shadow value, replays once,
// and tracks total and windowed error counts.
module error_recovery_ctrl
    import err_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 3,
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned CNT_WIDTH    = 8,
    parameter int unsigned WINDOW       = 16,
    parameter int unsigned THRESH       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  error,
    input  logic [DATA_WIDTH-1:0] main_q,
    input  logic [DATA_WIDTH-1:0] shadow_q,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  stall,
    output logic                  restore,
    output logic                  replay,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  overrun,
    output logic                  throttle
);

    localparam int unsigned SCNT_W = cnt_width(STALL_CYCLES + 1);

    state_e                r_state;
    logic [SCNT_W-1:0]     r_scnt;
    logic [DATA_WIDTH-1:0] r_corr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_stall;
    logic                  r_restore;
    logic                  r_replay;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_overrun;
    logic                  w_accept;
    logic                  w_throttle;

    // Errors are only accepted outside RECOVER; those inside are masked.
    assign w_accept = error && (r_state != RECOVER);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_scnt    <= '0;
            r_corr    <= '0;
            r_data    <= '0;
            r_stall   <= 1'b0;
            r_restore <= 1'b0;
            r_replay  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                IDLE, REPLAY: begin
                    if (error) begin
                        r_corr    <= shadow_q;
                        r_data    <= shadow_q;
                        r_stall   <= 1'b1;
                        r_restore <= 1'b1;
                        r_replay  <= 1'b0;
                        r_scnt    <= '0;
                        r_state   <= RECOVER;
                    end else begin
                        r_data    <= main_q;
                        r_stall   <= 1'b0;
                        r_restore <= 1'b0;
                        r_replay  <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                RECOVER: begin
                    r_data <= r_corr;
                    if (error) begin
                        r_overrun <= 1'b1;
                    end
                    if (r_scnt == SCNT_W'(STALL_CYCLES - 1)) begin
                        r_stall  <= 1'b0;
                        r_replay <= 1'b1;
                        r_state  <= REPLAY;
                    end else begin
                        r_scnt <= r_scnt + SCNT_W'(1);
                    end
                end
                default: begin
                    r_stall   <= 1'b0;
                    r_restore <= 1'b0;
                    r_replay  <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    // Saturating total of accepted errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    err_rate_monitor #(
        .WINDOW (WINDOW),
        .THRESH (THRESH)
    ) u_rate (
        .clk        (clk),
        .rst        (rst),
        .i_accept   (w_accept),
        .o_throttle (w_throttle)
    );

    assign data_out  = r_data;
    assign stall     = r_stall;
    assign restore   = r_restore;
    assign replay    = r_replay;
    assign err_count = r_cnt;
    assign overrun   = r_overrun;
    assign throttle  = w_throttle;

endmodule
